counter_scoreboard: RTL and testbench

- Cycle-accurate golden reference model of the 4-bit multi-mode counter (enable / modo / D in; Q / rco out).
- Driven by the same stimulus as the counter under test.
- Computes the expected Q and rco every clock and compares them against the counter's actual outputs, counting mismatches.
- Sits beside the counter in the verification environment; is synthesizable RTL.

---
 rtl/counter_scoreboard.sv | 136 +++++++++++++
 tb/tb_counter_scoreboard.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_scoreboard.sv
// counter_scoreboard: cycle-accurate golden model of the 4-bit multi-mode
// counter (up / down / down-by-3 / parallel load). It runs on the same
// stimulus as the counter under test, compares the counter's Q and rco
// against its own expected values and keeps saturating compare and error
// counts.
// Optional feature: define SB_STICKY_FAIL_EN to add a sticky 'fail' output.
module counter_scoreboard #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] dut_q,
  input  logic             dut_rco,
  input  logic             check_en,
  output logic [WIDTH-1:0] sb_q,
  output logic             sb_rco,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
`ifdef SB_STICKY_FAIL_EN
  output logic [ERR_W-1:0] cmp_count,
  output logic             fail
`else
  output logic [ERR_W-1:0] cmp_count
`endif
);

  localparam logic [WIDTH-1:0] Q_ONES  = '1;
  localparam logic [WIDTH-1:0] Q_ZERO  = '0;
  localparam logic [WIDTH-1:0] Q_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] Q_THREE = WIDTH'(3);
  localparam logic [ERR_W-1:0] C_ONE   = ERR_W'(1);

  typedef enum logic [1:0] {
    MODE_UP    = 2'b00,
    MODE_DOWN  = 2'b01,
    MODE_DOWN3 = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] sb_q_q, sb_q_d;
  logic             sb_rco_q, sb_rco_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [ERR_W-1:0] cmp_q, cmp_d;
  logic             diff;

  // Counters stick at all-ones instead of wrapping so a long run never
  // hides errors behind a rollover.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + C_ONE;
  endfunction

  // Expected next counter value and rco pulse from the current mode.
  always_comb begin
    sb_q_d   = sb_q_q;
    sb_rco_d = 1'b0;
    if (enable) begin
      unique case (mode_e'(modo))
        MODE_UP: begin
          sb_q_d   = sb_q_q + Q_ONE;
          sb_rco_d = (sb_q_q == Q_ONES);
        end
        MODE_DOWN: begin
          sb_q_d   = sb_q_q - Q_ONE;
          sb_rco_d = (sb_q_q == Q_ZERO);
        end
        MODE_DOWN3: begin
          sb_q_d   = sb_q_q - Q_THREE;
          sb_rco_d = (sb_q_q < Q_THREE);
        end
        default: begin
          sb_q_d   = D;
          sb_rco_d = 1'b0;
        end
      endcase
    end
  end

  // Compare against the counter; case-inequality flags X/Z as a mismatch in
  // simulation and reduces to a plain inequality in synthesis.
  always_comb begin
    diff     = (dut_q !== sb_q_q) || (dut_rco !== sb_rco_q);
    mismatch = ~reset & check_en & diff;
  end

  // Next values of the compare and error counters for a checked cycle.
  always_comb begin
    cmp_d = cmp_q;
    err_d = err_q;
    if (check_en) begin
      cmp_d = sat_inc(cmp_q);
      if (mismatch) begin
        err_d = sat_inc(err_q);
      end
    end
  end

  // Expected-value and counter state; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q_q   <= '0;
      sb_rco_q <= 1'b0;
      err_q    <= '0;
      cmp_q    <= '0;
    end else begin
      sb_q_q   <= sb_q_d;
      sb_rco_q <= sb_rco_d;
      err_q    <= err_d;
      cmp_q    <= cmp_d;
    end
  end

`ifdef SB_STICKY_FAIL_EN
  logic fail_q;

  // Sticky flag: first checked mismatch latches it until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_q <= 1'b0;
    end else if (check_en && mismatch) begin
      fail_q <= 1'b1;
    end
  end

  assign fail = fail_q;
`endif

  assign sb_q      = sb_q_q;
  assign sb_rco    = sb_rco_q;
  assign err_count = err_q;
  assign cmp_count = cmp_q;

endmodule

// File: tb/tb_counter_scoreboard.sv
// Self-checking bench for counter_scoreboard: directed vector table,
// hand-written asynchronous-reset and saturation sequences, then random
// stimulus, all checked against a behavioural model of the counter rules.
module tb_counter_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] modo;
  logic [3:0] D;
  logic [3:0] dut_q;
  logic       dut_rco;
  logic       check_en;

  logic [3:0]  q_a,   q_b;
  logic        rco_a, rco_b;
  logic        mm_a,  mm_b;
  logic [15:0] err_a, cmp_a;
  logic [3:0]  err_b, cmp_b;
`ifdef SB_STICKY_FAIL_EN
  logic        fail_a, fail_b;
`endif

  always #5 clk = ~clk;

  counter_scoreboard #(.WIDTH(4), .ERR_W(16)) u_main (
    .clk(clk), .reset(reset), .enable(enable), .modo(modo), .D(D),
    .dut_q(dut_q), .dut_rco(dut_rco), .check_en(check_en),
    .sb_q(q_a), .sb_rco(rco_a), .mismatch(mm_a),
    .err_count(err_a),
`ifdef SB_STICKY_FAIL_EN
    .cmp_count(cmp_a), .fail(fail_a)
`else
    .cmp_count(cmp_a)
`endif
  );

  counter_scoreboard #(.WIDTH(4), .ERR_W(4)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .modo(modo), .D(D),
    .dut_q(dut_q), .dut_rco(dut_rco), .check_en(check_en),
    .sb_q(q_b), .sb_rco(rco_b), .mismatch(mm_b),
    .err_count(err_b),
`ifdef SB_STICKY_FAIL_EN
    .cmp_count(cmp_b), .fail(fail_b)
`else
    .cmp_count(cmp_b)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: plain modular arithmetic on integers.
  int m_q, m_rco, m_err16, m_cmp16, m_err4, m_cmp4, m_fail;

  typedef struct {
    bit       en;
    bit [1:0] md;
    bit [3:0] d;
    bit       ck;
    bit [3:0] off;
    bit [3:0] eq;
    bit       erco;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit en, bit [1:0] md, bit [3:0] d, bit ck,
                              bit [3:0] off, bit [3:0] eq, bit erco);
    vec_t v;
    v.en = en; v.md = md; v.d = d; v.ck = ck; v.off = off; v.eq = eq; v.erco = erco;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_rco = 0; m_err16 = 0; m_cmp16 = 0; m_err4 = 0; m_cmp4 = 0; m_fail = 0;
  endtask

  task automatic check_outputs();
    chk("sb_q",        int'(q_a),   m_q);
    chk("sb_rco",      int'(rco_a), m_rco);
    chk("err_count",   int'(err_a), m_err16);
    chk("cmp_count",   int'(cmp_a), m_cmp16);
    chk("sb_q_w4",     int'(q_b),   m_q);
    chk("err_count_w4", int'(err_b), m_err4);
    chk("cmp_count_w4", int'(cmp_b), m_cmp4);
`ifdef SB_STICKY_FAIL_EN
    chk("fail",    int'(fail_a), m_fail);
    chk("fail_w4", int'(fail_b), m_fail);
`endif
  endtask

  // Called just after a rising edge: drive, check the combinational compare,
  // take one edge, advance the model and check the registered outputs.
  task automatic cycle(input bit en, input bit [1:0] md, input bit [3:0] d,
                       input bit ck, input bit [3:0] dq, input bit drco);
    bit mm;
    enable = en; modo = md; D = d; check_en = ck; dut_q = dq; dut_rco = drco;
    #1;
    mm = ck && ((int'(dq) != m_q) || (int'(drco) != m_rco));
    chk("mismatch",    int'(mm_a), int'(mm));
    chk("mismatch_w4", int'(mm_b), int'(mm));
    @(posedge clk);
    if (ck) begin
      m_cmp16 = (m_cmp16 < 65535) ? m_cmp16 + 1 : 65535;
      m_cmp4  = (m_cmp4 < 15) ? m_cmp4 + 1 : 15;
      if (mm) begin
        m_err16 = (m_err16 < 65535) ? m_err16 + 1 : 65535;
        m_err4  = (m_err4 < 15) ? m_err4 + 1 : 15;
        m_fail  = 1;
      end
    end
    if (!en) begin
      m_rco = 0;
    end else begin
      case (md)
        2'd0: begin m_rco = (m_q == 15); m_q = (m_q + 1) % 16;  end
        2'd1: begin m_rco = (m_q == 0);  m_q = (m_q + 15) % 16; end
        2'd2: begin m_rco = (m_q < 3);   m_q = (m_q + 13) % 16; end
        default: begin m_rco = 0; m_q = int'(d); end
      endcase
    end
    #1;
    check_outputs();
  endtask

  initial begin
    // Directed table: count-up wrap, down-by-3 borrow, down wrap, hold,
    // injected off-by-one errors, and unchecked mismatches.
    for (int i = 1; i <= 17; i++) add(1, 2'd0, 4'd0, 1, 4'd0, 4'(i % 16), (i == 16));
    add(1, 2'd3, 4'h2, 1, 4'd0, 4'd2,  1'b0);
    add(1, 2'd2, 4'h0, 1, 4'd0, 4'd15, 1'b1);
    add(1, 2'd2, 4'h0, 1, 4'd0, 4'd12, 1'b0);
    add(1, 2'd3, 4'h0, 1, 4'd0, 4'd0,  1'b0);
    add(1, 2'd1, 4'h0, 1, 4'd0, 4'd15, 1'b1);
    for (int i = 0; i < 3; i++) add(0, 2'd1, 4'h0, 1, 4'd0, 4'd15, 1'b0);
    add(0, 2'd0, 4'h0, 1, 4'd1, 4'd15, 1'b0);
    add(0, 2'd0, 4'h0, 1, 4'd1, 4'd15, 1'b0);
    add(0, 2'd0, 4'h0, 0, 4'd1, 4'd15, 1'b0);

    // Reset state; mismatch must stay low while reset is held.
    reset = 1'b1; enable = 1'b0; modo = 2'd0; D = 4'd0;
    check_en = 1'b1; dut_q = 4'd5; dut_rco = 1'b1;
    model_reset();
    #2;
    chk("rst_mismatch", int'(mm_a), 0);
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].en, tbl[i].md, tbl[i].d, tbl[i].ck,
            4'(m_q + int'(tbl[i].off)), m_rco[0]);
      chk("tbl_q",   int'(q_a),   int'(tbl[i].eq));
      chk("tbl_rco", int'(rco_a), int'(tbl[i].erco));
      if (i == 16) begin
        chk("err_after_17", int'(err_a), 0);
        chk("cmp_after_17", int'(cmp_a), 17);
      end
    end
    chk("tbl_err_total", int'(err_a), 2);
    chk("tbl_cmp_total", int'(cmp_a), 27);

    // Asynchronous reset between edges while sb_q is 9.
    cycle(1, 2'd3, 4'd9, 0, 4'd0, 1'b0);
    chk("pre_rst_q", int'(q_a), 9);
    check_en = 1'b1; dut_q = 4'd5;
    #2;
    reset = 1'b1;
    #1;
    chk("async_q",   int'(q_a),   0);
    chk("async_err", int'(err_a), 0);
    chk("async_cmp", int'(cmp_a), 0);
    chk("async_mm",  int'(mm_a),  0);
`ifdef SB_STICKY_FAIL_EN
    chk("async_fail", int'(fail_a), 0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First edge after reset counts down from 0.
    cycle(1, 2'd1, 4'd0, 1, 4'd0, 1'b0);
    chk("post_rst_q",   int'(q_a),   15);
    chk("post_rst_rco", int'(rco_a), 1);

    // Persistent mismatch well past the 4-bit counter range.
    for (int i = 0; i < 21; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
            1, 4'(m_q ^ 1), m_rco[0]);
    end
    chk("sat_err_w4", int'(err_b), 15);
    chk("sat_cmp_w4", int'(cmp_b), 15);
    chk("nosat_err",  int'(err_a), 21);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      bit [3:0] dq;
      bit       dr;
      dq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(m_q);
      dr = ($urandom_range(0, 7) == 0) ? 1'($urandom) : m_rco[0];
      cycle(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), 4'($urandom),
            1'($urandom_range(0, 1)), dq, dr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
